// File: rtl/axi_pkg.sv
// Shared helpers for the AXI ID-width converter blocks: width derivations
// used to size slot indices and per-slot transaction counters.
package axi_pkg;

  // MSB index of a field of width w, clamped so a zero-width request still
  // yields a legal one-bit vector.
  function automatic int unsigned iomsb(input int unsigned w);
    return (w > 0) ? w - 1 : 0;
  endfunction

  function automatic int unsigned idx_width(input int unsigned num_slots);
    return (num_slots > 1) ? $clog2(num_slots) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_txns);
    return $clog2(max_txns + 1);
  endfunction

endpackage

// File: rtl/axi_id_restore_table.sv
// Maps narrow master-port IDs back to the wide slave-port IDs they stand for.
// Optional illegal-operation checking: define AXI_ID_RESTORE_TABLE_CHECK_EN.
module axi_id_restore_table
  import axi_pkg::*;
#(
  parameter int unsigned InpIdWidth    = 4,
  parameter int unsigned MaxUniqInpIds = 4,
  parameter int unsigned MaxTxnsPerId  = 4,
  localparam int unsigned IdxWidth     = idx_width(MaxUniqInpIds),
  localparam int unsigned CntWidth     = cnt_width(MaxTxnsPerId)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  full_o,
  output logic [IdxWidth-1:0]   free_oup_id_o,
  input  logic [InpIdWidth-1:0] exists_inp_id_i,
  output logic                  exists_o,
  output logic [IdxWidth-1:0]   exists_oup_id_o,
  output logic                  exists_full_o,
  input  logic                  push_i,
  input  logic [InpIdWidth-1:0] push_inp_id_i,
  input  logic [IdxWidth-1:0]   push_oup_id_i,
  input  logic                  pop_i,
  input  logic [IdxWidth-1:0]   pop_oup_id_i,
  output logic [InpIdWidth-1:0] pop_inp_id_o,
  output logic                  err_o
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTxnsPerId);

  typedef struct packed {
    logic [iomsb(InpIdWidth):0] inp_id;
    logic [iomsb(CntWidth):0]   cnt;
  } entry_t;

  entry_t                   slot_reg [MaxUniqInpIds];
  logic [MaxUniqInpIds-1:0] in_use;
  logic [MaxUniqInpIds-1:0] match;
  logic [MaxUniqInpIds-1:0] match_full;

  generate
    for (genvar gi = 0; gi < MaxUniqInpIds; gi++) begin : g_slot
      logic push_hit;
      logic pop_hit;

      assign in_use[gi]     = (slot_reg[gi].cnt != '0);
      assign match[gi]      = in_use[gi] && (slot_reg[gi].inp_id == exists_inp_id_i);
      assign match_full[gi] = match[gi] && (slot_reg[gi].cnt == CntMax);
      assign push_hit       = push_i && (push_oup_id_i == IdxWidth'(gi));
      assign pop_hit        = pop_i && (pop_oup_id_i == IdxWidth'(gi));

      // A push and pop on the same slot cancel, so a count of 1 never
      // passes through 0 and the slot cannot be reallocated underneath.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          slot_reg[gi] <= '0;
        end else if (push_hit && !pop_hit) begin
          if (slot_reg[gi].cnt == '0) begin
            slot_reg[gi].inp_id <= push_inp_id_i;
          end
          if (slot_reg[gi].cnt != CntMax) begin
            slot_reg[gi].cnt <= slot_reg[gi].cnt + CntWidth'(1);
          end
        end else if (pop_hit && !push_hit && (slot_reg[gi].cnt != '0)) begin
          slot_reg[gi].cnt <= slot_reg[gi].cnt - CntWidth'(1);
        end
      end
    end
  endgenerate

  assign full_o        = &in_use;
  assign exists_o      = |match;
  assign exists_full_o = |match_full;

  // Lowest-index free slot.
  always_comb begin
    logic found;
    found         = 1'b0;
    free_oup_id_o = '0;
    for (int i = 0; i < MaxUniqInpIds; i++) begin
      if (!in_use[i] && !found) begin
        free_oup_id_o = IdxWidth'(i);
        found         = 1'b1;
      end
    end
  end

  // Match is one-hot by construction, so OR-ing indices encodes it.
  always_comb begin
    exists_oup_id_o = '0;
    for (int i = 0; i < MaxUniqInpIds; i++) begin
      if (match[i]) begin
        exists_oup_id_o = exists_oup_id_o | IdxWidth'(i);
      end
    end
  end

  always_comb begin
    pop_inp_id_o = '0;
    for (int i = 0; i < MaxUniqInpIds; i++) begin
      if (pop_oup_id_i == IdxWidth'(i)) begin
        pop_inp_id_o = slot_reg[i].inp_id;
      end
    end
  end

`ifdef AXI_ID_RESTORE_TABLE_CHECK_EN
  logic                  err_reg;
  logic                  err_next;
  logic [CntWidth-1:0]   push_cnt;
  logic [InpIdWidth-1:0] push_stored_id;
  logic [CntWidth-1:0]   pop_cnt;

  always_comb begin
    push_cnt       = '0;
    push_stored_id = '0;
    pop_cnt        = '0;
    for (int i = 0; i < MaxUniqInpIds; i++) begin
      if (push_oup_id_i == IdxWidth'(i)) begin
        push_cnt       = slot_reg[i].cnt;
        push_stored_id = slot_reg[i].inp_id;
      end
      if (pop_oup_id_i == IdxWidth'(i)) begin
        pop_cnt = slot_reg[i].cnt;
      end
    end
  end

  always_comb begin
    err_next = err_reg;
    if (push_i) begin
      if (push_cnt == CntMax) err_next = 1'b1;
      if ((push_cnt == '0) && full_o) err_next = 1'b1;
      if ((push_cnt != '0) && (push_stored_id != push_inp_id_i)) err_next = 1'b1;
    end
    if (pop_i && (pop_cnt == '0)) err_next = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_reg <= 1'b0;
    else         err_reg <= err_next;
  end

  assign err_o = err_reg;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi_id_restore_table.sv
// Table-driven bench for axi_id_restore_table with a scoreboard queue;
// error-flag expectations follow AXI_ID_RESTORE_TABLE_CHECK_EN.
module tb_axi_id_restore_table;

`ifdef AXI_ID_RESTORE_TABLE_CHECK_EN
  localparam bit ErrOn = 1'b1;
`else
  localparam bit ErrOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       full, exists, exists_full, push, pop, err;
  logic [1:0] free_id, exists_id, push_oup_id, pop_oup_id;
  logic [3:0] exists_inp_id, push_inp_id, pop_inp_id;

  always #5 clk = ~clk;

  axi_id_restore_table dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .full_o          (full),
    .free_oup_id_o   (free_id),
    .exists_inp_id_i (exists_inp_id),
    .exists_o        (exists),
    .exists_oup_id_o (exists_id),
    .exists_full_o   (exists_full),
    .push_i          (push),
    .push_inp_id_i   (push_inp_id),
    .push_oup_id_i   (push_oup_id),
    .pop_i           (pop),
    .pop_oup_id_i    (pop_oup_id),
    .pop_inp_id_o    (pop_inp_id),
    .err_o           (err)
  );

  typedef struct {
    logic       push;
    logic [3:0] push_id;
    logic [1:0] push_slot;
    logic       pop;
    logic [1:0] pop_slot;
    logic [3:0] look_id;
    logic       viol;
    logic       full;
    logic [1:0] free;
    logic       ex;
    logic [1:0] eid;
    logic       efull;
    logic [3:0] pop_id;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];
  vec_t sb_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic err_exp = 1'b0;

  task automatic check(input string nm, input int step, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, step, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic pu, input logic [3:0] pid, input logic [1:0] ps,
                              input logic po, input logic [1:0] pos, input logic [3:0] lk,
                              input logic vi, input logic fu, input logic [1:0] fr,
                              input logic ex, input logic [1:0] eid, input logic ef,
                              input logic [3:0] popid);
    vec_t v;
    v.push = pu; v.push_id = pid; v.push_slot = ps; v.pop = po; v.pop_slot = pos;
    v.look_id = lk; v.viol = vi; v.full = fu; v.free = fr; v.ex = ex; v.eid = eid;
    v.efull = ef; v.pop_id = popid;
    return v;
  endfunction

  task automatic idle_inputs();
    push = 1'b0; pop = 1'b0; push_inp_id = '0; push_oup_id = '0; pop_oup_id = '0;
  endtask

  initial begin
    vec_t e;
    //             push pid  ps  pop ps  look viol full free ex eid ef popid
    vecs[0]  = mk(1, 4'hA, 0, 0, 0, 4'hA, 0, 0, 1, 1, 0, 0, 4'hA);
    vecs[1]  = mk(1, 4'h3, 1, 0, 1, 4'hA, 0, 0, 2, 1, 0, 0, 4'h3);
    vecs[2]  = mk(1, 4'hA, 0, 0, 0, 4'hA, 0, 0, 2, 1, 0, 0, 4'hA);
    vecs[3]  = mk(1, 4'hA, 0, 0, 0, 4'hA, 0, 0, 2, 1, 0, 0, 4'hA);
    vecs[4]  = mk(1, 4'hA, 0, 0, 0, 4'hA, 0, 0, 2, 1, 0, 1, 4'hA);
    vecs[5]  = mk(0, 4'h0, 0, 1, 0, 4'hA, 0, 0, 2, 1, 0, 0, 4'hA);
    vecs[6]  = mk(0, 4'h0, 0, 1, 0, 4'hA, 0, 0, 2, 1, 0, 0, 4'hA);
    vecs[7]  = mk(0, 4'h0, 0, 1, 0, 4'hA, 0, 0, 2, 1, 0, 0, 4'hA);
    vecs[8]  = mk(1, 4'hA, 0, 1, 0, 4'hA, 0, 0, 2, 1, 0, 0, 4'hA);
    vecs[9]  = mk(0, 4'h0, 0, 1, 0, 4'hA, 0, 0, 0, 0, 0, 0, 4'hA);
    vecs[10] = mk(1, 4'h5, 0, 0, 0, 4'h3, 0, 0, 2, 1, 1, 0, 4'h5);
    vecs[11] = mk(1, 4'h9, 2, 0, 2, 4'h9, 0, 0, 3, 1, 2, 0, 4'h9);
    vecs[12] = mk(1, 4'hC, 3, 0, 3, 4'hC, 0, 1, 0, 1, 3, 0, 4'hC);
    vecs[13] = mk(0, 4'h0, 0, 1, 2, 4'h9, 0, 0, 2, 0, 0, 0, 4'h9);
    vecs[14] = mk(1, 4'h7, 2, 0, 2, 4'h7, 0, 1, 0, 1, 2, 0, 4'h7);
    vecs[15] = mk(1, 4'h7, 2, 1, 1, 4'h3, 0, 0, 1, 0, 0, 0, 4'h3);
    vecs[16] = mk(1, 4'h7, 2, 0, 2, 4'h7, 0, 0, 1, 1, 2, 0, 4'h7);
    vecs[17] = mk(1, 4'h7, 2, 0, 2, 4'h7, 0, 0, 1, 1, 2, 1, 4'h7);
    vecs[18] = mk(1, 4'h7, 2, 0, 2, 4'h7, 1, 0, 1, 1, 2, 1, 4'h7);
    vecs[19] = mk(0, 4'h0, 0, 1, 2, 4'h7, 0, 0, 1, 1, 2, 0, 4'h7);
    vecs[20] = mk(0, 4'h0, 0, 1, 2, 4'h7, 0, 0, 1, 1, 2, 0, 4'h7);
    vecs[21] = mk(0, 4'h0, 0, 1, 2, 4'h7, 0, 0, 1, 1, 2, 0, 4'h7);
    vecs[22] = mk(0, 4'h0, 0, 1, 2, 4'h7, 0, 0, 1, 0, 0, 0, 4'h7);
    vecs[23] = mk(0, 4'h0, 0, 1, 2, 4'h7, 1, 0, 1, 0, 0, 0, 4'h7);
    vecs[24] = mk(1, 4'h6, 1, 0, 1, 4'h6, 0, 0, 2, 1, 1, 0, 4'h6);

    rst_n = 1'b0;
    idle_inputs();
    exists_inp_id = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_full", -1, full, 0);
    check("rst_exists", -1, exists, 0);
    check("rst_free", -1, free_id, 0);
    check("rst_err", -1, err, 0);
    check("rst_pop_inp_id", -1, pop_inp_id, 0);

    for (int i = 0; i < NV; i++) begin
      sb_q.push_back(vecs[i]);
      push = vecs[i].push; push_inp_id = vecs[i].push_id; push_oup_id = vecs[i].push_slot;
      pop = vecs[i].pop; pop_oup_id = vecs[i].pop_slot; exists_inp_id = vecs[i].look_id;
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      if (e.viol && ErrOn) err_exp = 1'b1;
      check("full", i, full, e.full);
      if (!e.full) check("free_oup_id", i, free_id, e.free);
      check("exists", i, exists, e.ex);
      if (e.ex) check("exists_oup_id", i, exists_id, e.eid);
      check("exists_full", i, exists_full, e.efull);
      check("pop_inp_id", i, pop_inp_id, e.pop_id);
      check("err", i, err, err_exp);
      $display("step %0d: push=%0d id=%0h slot=%0d pop=%0d slot=%0d -> full=%0d free=%0d ex=%0d eid=%0d ef=%0d pid=%0h err=%0d",
               i, e.push, e.push_id, e.push_slot, e.pop, e.pop_slot, full, free_id, exists, exists_id,
               exists_full, pop_inp_id, err);
    end
    idle_inputs();

    // Asynchronous reset in the middle of a clock period, with slots in use.
    #2 rst_n = 1'b0;
    err_exp = 1'b0;
    #1;
    check("async_rst_full", 100, full, 0);
    check("async_rst_exists", 100, exists, 0);
    check("async_rst_free", 100, free_id, 0);
    check("async_rst_err", 100, err, 0);
    pop_oup_id = 2'd1;
    #1 check("async_rst_pop_inp_id", 100, pop_inp_id, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Pop of an empty slot: flags an error when checking is built in.
    pop = 1'b1; pop_oup_id = 2'd3;
    @(posedge clk);
    #1 idle_inputs();
    err_exp = ErrOn;
    check("err_pop_empty", 101, err, err_exp);
    check("pop_empty_free", 101, free_id, 0);
    $display("step 101: pop empty slot 3 -> err=%0d", err);

    push = 1'b1; push_inp_id = 4'hB; push_oup_id = 2'd0; exists_inp_id = 4'hB;
    @(posedge clk);
    #1 idle_inputs();
    check("err_sticky", 102, err, err_exp);
    check("push_b_exists", 102, exists, 1);
    check("push_b_free", 102, free_id, 1);
    $display("step 102: push B slot 0 -> ex=%0d free=%0d err=%0d", exists, free_id, err);

    repeat (2) @(posedge clk);
    #1 check("err_sticky_idle", 103, err, err_exp);

    #3 rst_n = 1'b0;
    err_exp = 1'b0;
    #1;
    check("rst2_err", 104, err, 0);
    check("rst2_exists", 104, exists, 0);
    check("rst2_full", 104, full, 0);
    check("rst2_free", 104, free_id, 0);
    check("rst2_pop_inp_id", 104, pop_inp_id, 0);
    $display("step 104: mid-run reset -> err=%0d ex=%0d full=%0d free=%0d", err, exists, full, free_id);
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
